multiword_cla_adder: RTL and testbench
======================================

# multiword_cla_adder

Sequential wide adder that sums two `W`-bit operands one `NBITS`-bit slice per cycle through a single `Parameterized_CLA` instance, rippling the carry through a register between slices. It sits directly upstream of the combinational CLA. It serialises wide operands into CLA-sized chunks and collects the slice sums into a full-width result. It is used where a `W`-bit CLA would be too large or too slow.

## Interface
- `NBITS`, default 4: slice width, passed to `Parameterized_CLA` as `nbits`.
- `WORDS`, default 4: number of slices; `W = NBITS*WORDS` (local, not overridable).
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset; one clock; reset is asynchronous and active-low.
- `start`  in  1: request; sampled only when `busy`=0.
- `a`  in  W: operand A; captured on the accepted `start` edge.
- `b`  in  W: operand B; captured on the accepted `start` edge.
- `cin`  in  1: carry-in; captured on the accepted `start` edge.
- `busy`  out  1: high while slices are being computed.
- `done`  out  1: one-cycle pulse when `sum`/`cout` update.
- `sum`  out  W: registered result; holds until the next completion.
- `cout`  out  1: registered carry-out of the MSB slice.
- `ovf`  out  1: signed overflow flag; see Configuration.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 latches `a`, `b` into shift registers and `cin` into the carry register.
  - Slice counter is cleared to 0 and the FSM moves to RUN.
- RUN, each cycle:
  - The CLA receives the low `NBITS` bits of both shift registers plus the carry register.
  - The slice sum is written into the working result at slice position `idx` (LSB slice first).
  - Carry register is loaded with the CLA `Cout`; operand registers shift right by `NBITS`; `idx` increments.
  - After the slice with `idx = WORDS-1`, the FSM moves to DONE.
- DONE, one cycle:
  - `sum` gets the working result, `cout` gets the carry register, `done`=1.
  - The FSM returns to IDLE, or to RUN if `start`=1 (back-to-back op; new operands latched).
- `busy` = 1 in RUN only. `start` is ignored in RUN, with no queuing.
- Operand changes on `a`/`b`/`cin` after capture have no effect on the op in flight.
- Arithmetic is unsigned modulo `2^W`; `{cout,sum}` = `a+b+cin`, exact in `W+1` bits.
- Counter width is `$clog2(WORDS)`, minimum 1. `WORDS=1` is legal and gives one RUN cycle.
- Reset (any time, including mid-RUN):
  - FSM goes to IDLE.
  - `busy`, `done`, `sum`, `cout`, `ovf`, working registers and counter all clear to 0.
  - An in-flight op is discarded and no `done` is produced for it.

## Timing
- The accepted `start` edge is edge 0.
- RUN occupies edges 1..WORDS.
- `done`, `sum`, `cout` and `ovf` are visible after edge WORDS+1, with `done` high for exactly that cycle.
- Latency is WORDS+1 cycles from `start` to `done`. Throughput is one op per WORDS+1 cycles with back-to-back `start`.
- `busy` rises after edge 0 and falls after edge WORDS.
- All outputs are registered. There is no combinational path from inputs to outputs.
- The CLA path is combinational within one cycle. The critical path is one `NBITS` CLA plus the carry register setup.

## Configuration
- Macro `MULTIWORD_CLA_OVF_EN`.
- Defined:
  - Capture the carry into the MSB of the final slice: `a[W-1]^b[W-1]^sum_bit[W-1]` on the last RUN cycle.
  - `ovf` = that carry XOR final carry-out, registered with `sum` in DONE.
  - This is two's-complement overflow.
- Undefined: the `ovf` port remains present and is tied to 0; no extra logic is built.

## Test plan
All cases use `NBITS`=4, `WORDS`=4.
- Reset: assert `rst_n`=0 asynchronously mid-cycle -> all outputs 0 immediately. After release with no `start`, outputs stay 0.
- Basic: `a`=16'h00FF, `b`=16'h0001, `cin`=0 -> `sum`=16'h0100, `cout`=0. `done` pulses exactly 5 cycles after the `start` edge; `busy` is high for 4 cycles.
- Full carry ripple: `a`=16'hFFFF, `b`=16'h0000, `cin`=1 -> `sum`=16'h0000, `cout`=1, `ovf`=0.
- Signed overflow: `a`=16'h7FFF, `b`=16'h0001, `cin`=0 -> `sum`=16'h8000, `cout`=0. `ovf`=1 with `MULTIWORD_CLA_OVF_EN`, 0 without.
- Handshake:
  - `start` pulsed during RUN is ignored, and the result matches the first operands.
  - `start` held through DONE begins a second op; `sum` keeps the first result until the second `done`.
- Reset mid-op: `rst_n` low at RUN `idx`=2 -> no `done`, outputs 0. A following op with `a`=16'h1234, `b`=16'h4321 gives `sum`=16'h5555, `cout`=0.

Source files
------------

// File: rtl/multiword_cla_adder_if.sv
// Bus bundle for multiword_cla_adder: request, captured operands and registered results.
// The slave modport is the adder side; the master modport is the requester side.
interface multiword_cla_adder_if #(
  parameter int unsigned W = 16
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/multiword_cla_adder.sv
// Serial W-bit adder: one NBITS slice per cycle through a single Parameterized_CLA, carry
// rippled via a register. Optional signed-overflow flag under `MULTIWORD_CLA_OVF_EN.
module Parameterized_CLA #(
  parameter int unsigned nbits = 4
) (
  input  logic [nbits-1:0] A,
  input  logic [nbits-1:0] B,
  input  logic             Cin,
  output logic [nbits-1:0] S,
  output logic             Cout
);
  logic [nbits-1:0] w_g;
  logic [nbits-1:0] w_p;
  logic [nbits:0]   w_c;

  assign w_g = A & B;
  assign w_p = A ^ B;

  // Each carry is expanded as a flat sum of products of g/p terms and Cin.
  always_comb begin
    logic w_pp;
    w_c    = '0;
    w_c[0] = Cin;
    for (int i = 0; i < int'(nbits); i++) begin
      w_c[i+1] = w_g[i];
      w_pp     = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_c[i+1] = w_c[i+1] | (w_pp & w_g[j]);
        w_pp     = w_pp & w_p[j];
      end
      w_c[i+1] = w_c[i+1] | (w_pp & Cin);
    end
  end

  assign S    = w_p ^ w_c[nbits-1:0];
  assign Cout = w_c[nbits];
endmodule

module multiword_cla_adder #(
  parameter int unsigned NBITS = 4,
  parameter int unsigned WORDS = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  multiword_cla_adder_if.slave  io_bus
);
  localparam int unsigned W    = NBITS * WORDS;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_work;
  logic [W-1:0]      r_sum;
  logic              r_carry;
  logic              r_cout;
  logic              r_done;
  logic [IdxW-1:0]   r_idx;
  logic              w_load;
  logic              w_step;
  logic              w_finish;
  logic              w_last;
  logic [NBITS-1:0]  w_slice_s;
  logic              w_slice_cout;
  int unsigned       w_base;

  assign w_last = (r_idx == IdxW'(WORDS - 1));
  assign w_base = 32'(r_idx) * NBITS;

  Parameterized_CLA #(
    .nbits(NBITS)
  ) u_cla (
    .A    (r_a[NBITS-1:0]),
    .B    (r_b[NBITS-1:0]),
    .Cin  (r_carry),
    .S    (w_slice_s),
    .Cout (w_slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (io_bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        w_step = 1'b1;
        if (w_last) w_state_nxt = StDone;
      end
      StDone: begin
        w_finish = 1'b1;
        if (io_bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = StRun;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // In DONE a new load and the result commit share the edge; r_cout sees the old carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_a     <= io_bus.a;
        r_b     <= io_bus.b;
        r_carry <= io_bus.cin;
        r_idx   <= '0;
      end else if (w_step) begin
        r_work[w_base +: NBITS] <= w_slice_s;
        r_carry                 <= w_slice_cout;
        r_a                     <= r_a >> NBITS;
        r_b                     <= r_b >> NBITS;
        r_idx                   <= r_idx + 1'b1;
      end
      if (w_finish) begin
        r_sum  <= r_work;
        r_cout <= r_carry;
      end
    end
  end

`ifdef MULTIWORD_CLA_OVF_EN
  logic r_c_msb;
  logic r_ovf;

  // Carry into the MSB recovered from the MSB sum bit of the last slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_step && w_last) begin
        r_c_msb <= r_a[NBITS-1] ^ r_b[NBITS-1] ^ w_slice_s[NBITS-1];
      end
      if (w_finish) r_ovf <= r_c_msb ^ r_carry;
    end
  end

  assign io_bus.ovf = r_ovf;
`else
  assign io_bus.ovf = 1'b0;
`endif

  assign io_bus.busy = (r_state == StRun);
  assign io_bus.done = r_done;
  assign io_bus.sum  = r_sum;
  assign io_bus.cout = r_cout;
endmodule

// File: tb/tb_multiword_cla_adder.sv
// Self-checking bench for multiword_cla_adder (NBITS=4, WORDS=4): directed cases plus
// random operands against an arithmetic reference model.
module tb_multiword_cla_adder;
  localparam int unsigned NBITS = 4;
  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = NBITS * WORDS;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  multiword_cla_adder_if #(.W(W)) bus ();

  multiword_cla_adder #(
    .NBITS (NBITS),
    .WORDS (WORDS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin);
`ifdef MULTIWORD_CLA_OVF_EN
    int s;
    s = int'($signed(a)) + int'($signed(b)) + int'(cin);
    return (s > 32767) || (s < -32768);
`else
    return 1'b0;
`endif
  endfunction

  // Runs one op; checks latency, busy duration, result and the single-cycle done pulse.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin);
    int lat;
    int busy_cnt;
    logic [W:0] exp;
    exp = ref_sum(a, b, cin);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = cin; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
      if (bus.done) break;
    end
    check({tag, " done_seen"}, 32'(bus.done), 32'd1);
    check({tag, " latency"}, 32'(lat), WORDS + 1);
    check({tag, " busy_cycles"}, 32'(busy_cnt), WORDS);
    check({tag, " sum"}, 32'(bus.sum), 32'(exp[W-1:0]));
    check({tag, " cout"}, 32'(bus.cout), 32'(exp[W]));
    check({tag, " ovf"}, 32'(bus.ovf), 32'(ref_ovf(a, b, cin)));
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   e1, e2;
    int           seen;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle sum", 32'(bus.sum), 32'd0);
    check("idle cout", 32'(bus.cout), 32'd0);
    check("idle flags", {29'd0, bus.busy, bus.done, bus.ovf}, 32'd0);

    do_op("basic", 16'h00FF, 16'h0001, 1'b0);
    do_op("ripple", 16'hFFFF, 16'h0000, 1'b1);
    do_op("sovf", 16'h7FFF, 16'h0001, 1'b0);
    do_op("nsovf", 16'h8000, 16'h8000, 1'b0);

    // Asynchronous reset mid-cycle clears registered results immediately.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst sum", 32'(bus.sum), 32'd0);
    check("async_rst flags", {28'd0, bus.busy, bus.done, bus.ovf, bus.cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // start pulsed while busy must be ignored.
    e1 = ref_sum(16'h1111, 16'h2222, 1'b1);
    @(negedge clk);
    bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.a = 16'hABCD; bus.b = 16'h9999; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("ign_start busy_low", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check("ign_start done", 32'(bus.done), 32'd1);
    check("ign_start sum", 32'(bus.sum), 32'(e1[W-1:0]));
    repeat (3) @(posedge clk);
    #1;
    check("ign_start no_second", 32'(bus.busy | bus.done), 32'd0);

    // start held through DONE launches a back-to-back op.
    e1 = ref_sum(16'h0F0F, 16'h00F1, 1'b0);
    e2 = ref_sum(16'hC350, 16'h4E20, 1'b1);
    @(negedge clk);
    bus.a = 16'h0F0F; bus.b = 16'h00F1; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    repeat (WORDS) @(posedge clk);
    #1;
    bus.a = 16'hC350; bus.b = 16'h4E20; bus.cin = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b first done", 32'(bus.done), 32'd1);
    check("b2b first sum", 32'(bus.sum), 32'(e1[W-1:0]));
    check("b2b busy_again", 32'(bus.busy), 32'd1);
    repeat (WORDS) @(posedge clk);
    #1;
    check("b2b sum_held", 32'(bus.sum), 32'(e1[W-1:0]));
    @(posedge clk); #1;
    check("b2b second done", 32'(bus.done), 32'd1);
    check("b2b second sum", 32'(bus.sum), 32'(e2[W-1:0]));
    check("b2b second cout", 32'(bus.cout), 32'(e2[W]));

    // Reset in the RUN cycle with idx=2 discards the op.
    @(negedge clk);
    bus.a = 16'hFFFF; bus.b = 16'h0001; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midop_rst outs", {12'd0, bus.sum, bus.busy, bus.done, bus.ovf, bus.cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen++;
    end
    check("midop_rst no_done", 32'(seen), 32'd0);
    do_op("after_rst", 16'h1234, 16'h4321, 1'b0);

    for (int n = 0; n < 30; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      do_op("rand", ra, rb, rc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end
endmodule
